// File: rtl/hazard_pkg.sv
// Shared constants, busy-FSM encoding and the register-hit helper for the hazard unit.
// Pure declarations: no latency, no flow control.
package hazard_pkg;
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   // Register $0 is hardwired, so a write to it can never create a dependency.
   function automatic logic reg_hit(input logic [4:0] wa,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       use_rs,
                                    input logic       use_rt);
      return (wa != REG_ZERO) && ((use_rs && (rs == wa)) || (use_rt && (rt == wa)));
   endfunction
endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Busy countdown for the multi-cycle HI/LO unit; md_busy rises the cycle after a start
// and stays up for exactly LAT cycles. Starts while busy are dropped and flagged in md_err.
module md_busy_timer
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_E,
   input  logic md_div_E,
   output logic md_busy,
   output logic md_err
);
   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             err_q;
   logic [CNT_W-1:0] lat_d;

   assign lat_d = md_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (md_start_E) begin
                  state_q <= BUSY;
                  cnt_q   <= lat_d;
                  busy_q  <= 1'b1;
               end
            end
            BUSY: begin
               // A second start cannot be honoured; keep the running op's timing.
               if (md_start_E)
                  err_q <= 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign md_busy = busy_q;
   assign md_err  = err_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use, branch-operand and HI/LO hazard detection for the 5-stage core.
// Stall/bubble decision is combinational (zero latency); stall_cnt saturates.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic        use_rs_D,
   input  logic        use_rt_D,
   input  logic        branch_D,
   input  logic        md_D,
   input  logic [4:0]  wa_E,
   input  logic        RegWrite_E,
   input  logic        load_E,
   input  logic [4:0]  wa_M,
   input  logic        load_M,
   input  logic        md_start_E,
   input  logic        md_div_E,
   output logic        stall_F,
   output logic        stall_D,
   output logic        clr_E,
   output logic        md_busy,
   output logic        md_err,
   output logic [31:0] stall_cnt
);
   logic        hit_E;
   logic        hit_M;
   logic        lu_haz;
   logic        br_haz;
   logic        md_haz;
   logic        stall;
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   md_busy_timer #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .md_start_E (md_start_E),
      .md_div_E   (md_div_E),
      .md_busy    (md_busy),
      .md_err     (md_err)
   );

   assign hit_E  = reg_hit(wa_E, rs_D, rt_D, use_rs_D, use_rt_D);
   assign hit_M  = reg_hit(wa_M, rs_D, rt_D, use_rs_D, use_rt_D);

   // A branch behind a load stalls twice: once with the load in E, once with it in M.
   assign lu_haz = load_E && RegWrite_E && hit_E;
   assign br_haz = branch_D && ((RegWrite_E && hit_E) || (load_M && hit_M));
   assign md_haz = md_D && (md_start_E || md_busy);
   assign stall  = lu_haz | br_haz | md_haz;

   assign stall_F = stall;
   assign stall_D = stall;
   assign clr_E   = stall;

   assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                    : stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: hazard equations, busy timing, sticky error, async abort.
module tb_hazard_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_D, rt_D, wa_E, wa_M;
   logic        use_rs_D, use_rt_D, branch_D, md_D;
   logic        RegWrite_E, load_E, load_M, md_start_E, md_div_E;
   logic        stall_F, stall_D, clr_E, md_busy, md_err;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   int busy_n;

   hazard_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .rs_D       (rs_D),
      .rt_D       (rt_D),
      .use_rs_D   (use_rs_D),
      .use_rt_D   (use_rt_D),
      .branch_D   (branch_D),
      .md_D       (md_D),
      .wa_E       (wa_E),
      .RegWrite_E (RegWrite_E),
      .load_E     (load_E),
      .wa_M       (wa_M),
      .load_M     (load_M),
      .md_start_E (md_start_E),
      .md_div_E   (md_div_E),
      .stall_F    (stall_F),
      .stall_D    (stall_D),
      .clr_E      (clr_E),
      .md_busy    (md_busy),
      .md_err     (md_err),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_stall(input string tag, input logic exp);
      chk({tag, "_F"}, {31'd0, stall_F}, {31'd0, exp});
      chk({tag, "_D"}, {31'd0, stall_D}, {31'd0, exp});
      chk({tag, "_clr"}, {31'd0, clr_E}, {31'd0, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs_D = 0; rt_D = 0; wa_E = 0; wa_M = 0;
      use_rs_D = 0; use_rt_D = 0; branch_D = 0; md_D = 0;
      RegWrite_E = 0; load_E = 0; load_M = 0; md_start_E = 0; md_div_E = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      #2;
      chk("rst_busy", {31'd0, md_busy}, 32'd0);
      chk("rst_err", {31'd0, md_err}, 32'd0);
      chk("rst_cnt", stall_cnt, 32'd0);
      chk_stall("rst_stall", 1'b0);
      #1 reset = 1'b0;
      step();

      // Load-use: one bubble, then the load sits in M and the dependency clears.
      load_E = 1; RegWrite_E = 1; wa_E = 8; use_rs_D = 1; rs_D = 8;
      #1 chk_stall("lu", 1'b1);
      step();
      load_E = 0; RegWrite_E = 0; wa_E = 0; load_M = 1; wa_M = 8;
      #1 chk_stall("lu_release", 1'b0);
      chk("lu_cnt", stall_cnt, 32'd1);

      // Register zero never stalls.
      do_reset();
      load_E = 1; RegWrite_E = 1; wa_E = 0; use_rs_D = 1; rs_D = 0;
      #1 chk_stall("r0", 1'b0);
      step();
      chk("r0_cnt", stall_cnt, 32'd0);

      // rt matches but is not read.
      load_E = 1; RegWrite_E = 1; wa_E = 7; use_rs_D = 0; use_rt_D = 0; rt_D = 7;
      #1 chk_stall("rt_unused", 1'b0);
      // ALU producer in E, no branch: forwarding covers it.
      load_E = 0; use_rs_D = 1; rs_D = 3; wa_E = 3;
      #1 chk_stall("alu_nobr", 1'b0);
      branch_D = 1;
      #1 chk_stall("alu_br", 1'b1);
      step();
      RegWrite_E = 0; wa_E = 0;
      #1 chk_stall("alu_br_rel", 1'b0);

      // Branch after load: two stall cycles.
      do_reset();
      load_E = 1; RegWrite_E = 1; wa_E = 9; branch_D = 1; use_rt_D = 1; rt_D = 9;
      #1 chk_stall("brld_1", 1'b1);
      step();
      load_E = 0; RegWrite_E = 0; wa_E = 0; load_M = 1; wa_M = 9;
      #1 chk_stall("brld_2", 1'b1);
      step();
      load_M = 0; wa_M = 0;
      #1 chk_stall("brld_rel", 1'b0);
      chk("brld_cnt", stall_cnt, 32'd2);

      // Mult sequencing with md_D held.
      do_reset();
      step();
      md_start_E = 1; md_div_E = 0; md_D = 1;
      #1 chk_stall("mul_t0", 1'b1);
      chk("mul_t0_busy", {31'd0, md_busy}, 32'd0);
      step();
      md_start_E = 0;
      for (int i = 1; i <= 5; i++) begin
         #1;
         chk($sformatf("mul_busy%0d", i), {31'd0, md_busy}, 32'd1);
         chk_stall($sformatf("mul_st%0d", i), 1'b1);
         step();
      end
      #1 chk("mul_end_busy", {31'd0, md_busy}, 32'd0);
      chk_stall("mul_rel", 1'b0);
      chk("mul_cnt", stall_cnt, 32'd6);
      chk("mul_err", {31'd0, md_err}, 32'd0);

      // Div duration: ten busy cycles.
      do_reset();
      md_start_E = 1; md_div_E = 1;
      step();
      md_start_E = 0; md_div_E = 0;
      busy_n = 0;
      for (int i = 0; i < 13; i++) begin
         if (md_busy) busy_n++;
         step();
      end
      chk("div_len", busy_n, 32'd10);

      // Second start on the 3rd busy cycle: sticky error, original timing kept.
      do_reset();
      md_start_E = 1;
      step();
      md_start_E = 0;
      step();
      step();
      md_start_E = 1;
      #1 chk("err_busy3", {31'd0, md_busy}, 32'd1);
      step();
      md_start_E = 0;
      #1 chk("err_set", {31'd0, md_err}, 32'd1);
      step();
      chk("err_busy5", {31'd0, md_busy}, 32'd1);
      step();
      chk("err_end", {31'd0, md_busy}, 32'd0);
      step();
      step();
      chk("err_sticky", {31'd0, md_err}, 32'd1);

      // Div aborted by an asynchronous reset, then a clean mult.
      do_reset();
      md_start_E = 1; md_div_E = 1; md_D = 1;
      step();
      md_start_E = 0; md_div_E = 0;
      step(); step(); step();
      chk("abort_pre", {31'd0, md_busy}, 32'd1);
      chk("abort_pre_cnt", stall_cnt, 32'd4);
      #1 reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, md_busy}, 32'd0);
      chk("abort_cnt", stall_cnt, 32'd0);
      chk("abort_err", {31'd0, md_err}, 32'd0);
      md_D = 0;
      #1 reset = 1'b0;
      step();
      md_start_E = 1;
      step();
      md_start_E = 0;
      busy_n = 0;
      for (int i = 0; i < 8; i++) begin
         if (md_busy) busy_n++;
         step();
      end
      chk("abort_mul_len", busy_n, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multiply/divide scheduler for the 5-stage MIPS core. It detects load-use, branch-operand and HI/LO-unit hazards between the D, E and M stages. On a hazard it freezes the PC and IF/ID registers and drives the `clr` input of the ID/EX register to inject a bubble. It also owns the busy timer that sequences the multi-cycle multiply/divide unit started from E.

## Interface
Parameters:
- `MULT_LAT`, default 5: cycles the mult unit stays busy after a start.
- `DIV_LAT`, default 10: cycles the div unit stays busy after a start.
- `CNT_W`, default 4: width of the busy countdown; must hold `max(MULT_LAT, DIV_LAT)`.

Ports:
- `clk` input, 1 bit: system clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `rs_D`, `rt_D` input, 5 bits each: source register fields of the D-stage instruction.
- `use_rs_D`, `use_rt_D` input, 1 bit each: the D instruction reads that operand.
- `branch_D` input, 1 bit: the D instruction is a branch/jr that compares or uses registers in D.
- `md_D` input, 1 bit: the D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `wa_E` input, 5 bits: destination register of the E instruction.
- `RegWrite_E` input, 1 bit: the E instruction writes `wa_E`.
- `load_E` input, 1 bit: the E instruction is a load.
- `wa_M` input, 5 bits: destination register of the M instruction.
- `load_M` input, 1 bit: the M instruction is a load that writes `wa_M`.
- `md_start_E` input, 1 bit: the E instruction starts a mult/div this cycle.
- `md_div_E` input, 1 bit: the started op is a divide (1) or a multiply (0).
- `stall_F` output, 1 bit: hold the PC.
- `stall_D` output, 1 bit: hold IF/ID.
- `clr_E` output, 1 bit: clear ID/EX at the next edge.
- `md_busy` output, 1 bit: the HI/LO unit is computing.
- `md_err` output, 1 bit: sticky flag; a start arrived while the unit was busy.
- `stall_cnt` output, 32 bits: count of stall cycles, for performance measurement.

## Operation
- Define `hit(wa) = wa != 0 && ((use_rs_D && rs_D == wa) || (use_rt_D && rt_D == wa))`.
- `lu_haz = load_E && RegWrite_E && hit(wa_E)`.
- `br_haz = branch_D && ((RegWrite_E && hit(wa_E)) || (load_M && hit(wa_M)))`.
- `md_haz = md_D && (md_start_E || md_busy)`.
- `stall = lu_haz | br_haz | md_haz`.
- `stall_F = stall_D = clr_E = stall`; all three are combinational in the same cycle.
- Busy FSM states:
  - IDLE: `md_busy` = 0.
    - On `md_start_E`, go to BUSY and load `cnt` with `md_div_E ? DIV_LAT : MULT_LAT`.
  - BUSY: `md_busy` = 1; `cnt` decrements each cycle.
    - When `cnt == 1`, return to IDLE at that edge.
- `md_start_E` while in BUSY: the start is ignored (no counter reload) and `md_err` is set. `md_err` stays set until reset.
- `stall_cnt` increments on every edge where `stall` = 1 and saturates at `32'hFFFF_FFFF`.
- Reset values: state IDLE, `cnt` 0, `md_busy` 0, `md_err` 0, `stall_cnt` 0. Stall outputs then follow only the inputs.

## Timing
- Stall decision has zero latency: the hazard and `stall` are visible in the same cycle.
- A start with `md_start_E` = 1 in cycle t gives `md_busy` = 1 in cycles t+1 through t+LAT, and 0 in cycle t+LAT+1.
- An `md_D` instruction is stalled in cycle t (via the `md_start_E` term) and in cycles t+1 through t+LAT. It advances in cycle t+LAT+1.
- A load-use hazard stalls exactly 1 cycle. The bubble moves the load to M, which clears `lu_haz`.
- A branch depending on an E-stage ALU result stalls 1 cycle. A branch depending on a load in E stalls 2 cycles: the first via `lu_haz`/`br_haz`, the second via the `load_M` term.
- Simultaneous hazards are ORed; at most one bubble is inserted per cycle.
- Asserting `reset` mid-BUSY forces IDLE immediately, without waiting for a clock. `md_busy` drops asynchronously.
- `wa == 0` never causes a stall.

## Structure
- Shared package `hazard_pkg`: `MULT_LAT` and `DIV_LAT` defaults, the FSM state encoding (IDLE = 0, BUSY = 1), and a register-zero constant.
- One natural sub-module, `md_busy_timer`: holds the FSM, `cnt` and `md_err`; its inputs are `clk`, `reset`, `md_start_E`, `md_div_E`; its output is `md_busy`.
- Hazard equations and `stall_cnt` stay in the top level.

## Test plan
- Load-use: `load_E` = 1, `RegWrite_E` = 1, `wa_E` = 8, `use_rs_D` = 1, `rs_D` = 8 -> `stall_F`/`stall_D`/`clr_E` = 1 for exactly 1 cycle; `stall_cnt` = 1.
- Register-zero: same as above with `wa_E` = 0 and `rs_D` = 0 -> no stall.
- Mult sequencing: `md_start_E` = 1, `md_div_E` = 0 in cycle 10, `md_D` held at 1 -> `md_busy` = 1 in cycles 11–15; stall in cycles 10–15; released in cycle 16; `stall_cnt` = 6.
- Div with abort: start a div in cycle 0 and assert `reset` in cycle 4 -> `md_busy` = 0 immediately and `stall_cnt` = 0. A following mult start gives 5 busy cycles.
- Error: a second `md_start_E` at the 3rd busy cycle of a mult -> `md_err` = 1 sticky; busy still ends after the original 5 cycles.
- Branch after load: `load_E` with `wa_E` = 9, then `branch_D` with `rt_D` = 9 and `use_rt_D` = 1 -> 2 consecutive stall cycles, then release.
